// File: rtl/ppu_vram_writer_if.sv
// Command and data-stream handshake bundle between a VRAM update source and
// the ppu_vram_writer burst engine.
interface ppu_vram_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_target;
  logic [12:0] cmd_addr;
  logic [12:0] cmd_count;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;

  modport master (
    output cmd_valid, cmd_target, cmd_addr, cmd_count, data_valid, data,
    input  cmd_ready, data_ready
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_addr, cmd_count, data_valid, data,
    output cmd_ready, data_ready
  );
endinterface

// File: rtl/ppu_vram_writer.sv
// Burst write engine for the PPU tile/pattern RAM B ports: one command, then a
// stream of 32-bit words, each landing as a byte-enabled half of a 64-bit word.
module ppu_vram_writer #(
  parameter int TIL_AW = 11,
  parameter int PAT_AW = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  ppu_vram_writer_if.slave    bus,
  input  logic                window,
  output logic [TIL_AW-1:0]   tilram_addr,
  output logic [63:0]         tilram_wrdata,
  output logic [7:0]          tilram_byteena,
  output logic                tilram_wren,
  output logic [PAT_AW-1:0]   patram_addr,
  output logic [63:0]         patram_wrdata,
  output logic [7:0]          patram_byteena,
  output logic                patram_wren,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_target;
  logic [12:0]         r_addr;
  logic [12:0]         r_count;
  logic                w_cmd_hs, w_data_hs;

  logic [TIL_AW-1:0]   r_til_addr;
  logic [63:0]         r_til_wrdata;
  logic [7:0]          r_til_byteena;
  logic                r_til_wren;
  logic [PAT_AW-1:0]   r_pat_addr;
  logic [63:0]         r_pat_wrdata;
  logic [7:0]          r_pat_byteena;
  logic                r_pat_wren;

  function automatic logic [7:0] half_be(input logic hi);
    return hi ? 8'hF0 : 8'h0F;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.cmd_ready  = 1'b0;
    bus.data_ready = 1'b0;
    w_cmd_hs       = 1'b0;
    w_data_hs      = 1'b0;
    case (r_state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_cmd_hs    = 1'b1;
          w_state_nxt = (bus.cmd_count == 13'd0) ? DONE : XFER;
        end
      end
      XFER: begin
        bus.data_ready = window;
        if (bus.data_valid && window) begin
          w_data_hs = 1'b1;
          if (r_count == 13'd1) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: address runs in 32-bit units; tile RAM only sees bits 11:1
  // so its wrap at 4096 falls out of the 13-bit counter naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= 1'b0;
      r_addr   <= 13'd0;
      r_count  <= 13'd0;
    end else if (w_cmd_hs) begin
      r_target <= bus.cmd_target;
      r_addr   <= bus.cmd_addr;
      r_count  <= bus.cmd_count;
    end else if (w_data_hs) begin
      r_addr   <= r_addr + 13'd1;
      r_count  <= r_count - 13'd1;
    end
  end

  // Write stage: one cycle after the handshake; the untargeted RAM holds its outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_til_addr    <= '0;
      r_til_wrdata  <= '0;
      r_til_byteena <= '0;
      r_til_wren    <= 1'b0;
      r_pat_addr    <= '0;
      r_pat_wrdata  <= '0;
      r_pat_byteena <= '0;
      r_pat_wren    <= 1'b0;
    end else begin
      r_til_wren <= 1'b0;
      r_pat_wren <= 1'b0;
      if (w_data_hs) begin
        if (r_target) begin
          r_pat_addr    <= r_addr[PAT_AW:1];
          r_pat_wrdata  <= {bus.data, bus.data};
          r_pat_byteena <= half_be(r_addr[0]);
          r_pat_wren    <= 1'b1;
        end else begin
          r_til_addr    <= r_addr[TIL_AW:1];
          r_til_wrdata  <= {bus.data, bus.data};
          r_til_byteena <= half_be(r_addr[0]);
          r_til_wren    <= 1'b1;
        end
      end
    end
  end

  assign tilram_addr    = r_til_addr;
  assign tilram_wrdata  = r_til_wrdata;
  assign tilram_byteena = r_til_byteena;
  assign tilram_wren    = r_til_wren;
  assign patram_addr    = r_pat_addr;
  assign patram_wrdata  = r_pat_wrdata;
  assign patram_byteena = r_pat_byteena;
  assign patram_wren    = r_pat_wren;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);

endmodule
